// File: rtl/data_mem_responder.sv
// data_mem_responder: word-addressed data memory behind the multicycle core's
// memread/memwrite strobes. Each access is captured in IDLE, waits a fixed
// number of wait states, then completes with a one-cycle ready pulse.
module data_mem_responder #(
  parameter int unsigned DW          = 16,
  parameter int unsigned AW          = 8,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memread,
  input  logic          memwrite,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          ready,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state, state_d;
  logic [3:0]    cnt, cnt_d;
  logic          rd_q, wr_q, err_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic          req;
  logic          enter_resp;
  logic          eff_rd, eff_wr;
  logic [AW-1:0] eff_addr;
  logic [DW-1:0] eff_wdata;
  logic          addr_ok;

  logic [DW-1:0] mem [DEPTH];

  assign req = memread | memwrite;

  // With zero wait states the access completes on the capture edge itself,
  // so the live inputs stand in for the not-yet-captured registers.
  always_comb begin
    eff_rd    = rd_q;
    eff_wr    = wr_q;
    eff_addr  = addr_q;
    eff_wdata = wdata_q;
    if (state == IDLE) begin
      eff_rd    = memread;
      eff_wr    = memwrite;
      eff_addr  = addr;
      eff_wdata = wdata;
    end
    addr_ok = (32'(eff_addr) < DEPTH);
  end

  // Next-state and wait-counter logic
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, capture registers, error flag and read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (state == IDLE && req) begin
        rd_q    <= memread;
        wr_q    <= memwrite;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (enter_resp) begin
        err_q <= ~addr_ok | (eff_rd & eff_wr);
        // A read+write conflict is serviced as a write and leaves rdata alone.
        if (eff_rd && !eff_wr) begin
          rdata <= addr_ok ? mem[eff_addr] : '0;
        end
      end
    end
  end

  // Array write commits on the edge entering RESP; contents are never reset
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && eff_wr && addr_ok) begin
      mem[eff_addr] <= eff_wdata;
    end
  end

  assign ready = (state == RESP);
  assign busy  = (state != IDLE);
  assign err   = ready & err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (1 wait state / depth 256,
// 3 wait states / depth 200, 0 wait states) driven by directed and random
// accesses and compared against an array-based reference model.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        memread [3];
  logic        memwrite[3];
  logic [7:0]  addr    [3];
  logic [15:0] wdata   [3];
  logic [15:0] rdata   [3];
  logic        ready   [3];
  logic        busy    [3];
  logic        err     [3];

  int unsigned depth_k[3] = '{256, 200, 256};
  int unsigned wc_k   [3] = '{1, 3, 0};

  logic [15:0] mem_m  [3][256];
  bit          known  [3][256];
  logic [15:0] rdata_m[3];
  bit          rdk    [3];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DW(16), .AW(8), .DEPTH(256), .WAIT_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .memread(memread[0]), .memwrite(memwrite[0]),
    .addr(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]),
    .busy(busy[0]), .err(err[0]));

  data_mem_responder #(.DW(16), .AW(8), .DEPTH(200), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .memread(memread[1]), .memwrite(memwrite[1]),
    .addr(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]),
    .busy(busy[1]), .err(err[1]));

  data_mem_responder #(.DW(16), .AW(8), .DEPTH(256), .WAIT_CYCLES(0)) u_dut2 (
    .clk(clk), .rst(rst), .memread(memread[2]), .memwrite(memwrite[2]),
    .addr(addr[2]), .wdata(wdata[2]), .rdata(rdata[2]), .ready(ready[2]),
    .busy(busy[2]), .err(err[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s_ready%0d", tag, k), ready[k], 0);
      chk($sformatf("%s_busy%0d", tag, k), busy[k], 0);
      chk($sformatf("%s_err%0d", tag, k), err[k], 0);
      chk($sformatf("%s_rdata%0d", tag, k), rdata[k], 0);
    end
  endtask

  // One complete access on instance k; expected behaviour comes from the model.
  task automatic access(input int k, input bit rd, input bit wr,
                        input logic [7:0] a, input logic [15:0] d);
    bit ok;
    bit e;
    int unsigned lat;
    ok  = (a < depth_k[k]);
    e   = !ok || (rd && wr);
    lat = wc_k[k] + 1;
    if (wr) begin
      if (ok) begin
        mem_m[k][a] = d;
        known[k][a] = 1'b1;
      end
    end else if (rd) begin
      if (ok) begin
        rdata_m[k] = mem_m[k][a];
        rdk[k]     = known[k][a];
      end else begin
        rdata_m[k] = '0;
        rdk[k]     = 1'b1;
      end
    end
    @(negedge clk);
    memread[k]  = rd;
    memwrite[k] = wr;
    addr[k]     = a;
    wdata[k]    = d;
    chk($sformatf("idle_busy%0d", k), busy[k], 0);
    for (int unsigned n = 1; n <= lat; n++) begin
      @(negedge clk);
      addr[k]  = 8'($urandom);
      wdata[k] = 16'($urandom);
      chk($sformatf("busy%0d_c%0d", k, n), busy[k], 1);
      chk($sformatf("ready%0d_c%0d", k, n), ready[k], (n == lat));
      chk($sformatf("err%0d_c%0d", k, n), err[k], (n == lat) ? e : 1'b0);
    end
    if (rdk[k]) chk($sformatf("rdata%0d_a%h", k, a), rdata[k], rdata_m[k]);
    memread[k]  = 1'b0;
    memwrite[k] = 1'b0;
    @(negedge clk);
    chk($sformatf("post_busy%0d", k), busy[k], 0);
    chk($sformatf("post_ready%0d", k), ready[k], 0);
    if (rdk[k]) chk($sformatf("hold_rdata%0d", k), rdata[k], rdata_m[k]);
  endtask

  initial begin
    int k;
    int r;
    int p;
    logic [7:0] a;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      memread[i]  = 1'b0;
      memwrite[i] = 1'b0;
      addr[i]     = '0;
      wdata[i]    = '0;
      rdata_m[i]  = '0;
      rdk[i]      = 1'b1;
      for (int j = 0; j < 256; j++) begin
        known[i][j] = 1'b0;
        mem_m[i][j] = '0;
      end
    end
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // Write then read back; rdata is not disturbed by later writes
    access(0, 0, 1, 8'h05, 16'hBEEF);
    access(0, 1, 0, 8'h05, 16'h0000);
    access(0, 0, 1, 8'h05, 16'h1111);
    access(0, 1, 0, 8'h05, 16'h0000);
    // Read+write conflict: write wins, err, rdata unchanged
    access(0, 1, 1, 8'h10, 16'h1234);
    access(0, 1, 0, 8'h10, 16'h0000);

    // Depth 200 bounds
    access(1, 0, 1, 8'h00, 16'h1357);
    access(1, 0, 1, 8'hC7, 16'h2468);
    access(1, 1, 0, 8'hC7, 16'h0000);
    access(1, 1, 0, 8'hC8, 16'h0000);
    access(1, 0, 1, 8'hC8, 16'hFFFF);
    access(1, 1, 0, 8'h00, 16'h0000);
    access(1, 1, 0, 8'hC8, 16'h0000);

    // Reset in the middle of a write: aborted, nothing committed
    access(0, 0, 1, 8'h20, 16'h5555);
    @(negedge clk);
    memwrite[0] = 1'b1;
    addr[0]     = 8'h20;
    wdata[0]    = 16'hAAAA;
    @(posedge clk);
    #2;
    chk("mid_busy0", busy[0], 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    memwrite[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rdata_m[i] = '0;
      rdk[i]     = 1'b1;
    end
    access(0, 1, 0, 8'h20, 16'h0000);

    // Zero wait states with memread held: ready on every second cycle
    access(2, 0, 1, 8'h07, 16'hC0DE);
    @(negedge clk);
    memread[2] = 1'b1;
    addr[2]    = 8'h07;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      chk($sformatf("held_ready_c%0d", n), ready[2], n[0]);
      if (n[0]) chk($sformatf("held_rdata_c%0d", n), rdata[2], 16'hC0DE);
    end
    memread[2] = 1'b0;
    rdata_m[2] = 16'hC0DE;
    rdk[2]     = 1'b1;
    @(negedge clk);
    chk("held_idle_busy", busy[2], 0);

    // Random traffic across all three instances
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 2);
      r = $urandom_range(0, 9);
      p = $urandom_range(0, 3);
      case (p)
        0:       a = 8'($urandom_range(0, 7));
        1:       a = 8'($urandom_range(196, 203));
        2:       a = 8'hFF;
        default: a = 8'($urandom);
      endcase
      if (r < 4)      access(k, 1, 0, a, 16'($urandom));
      else if (r < 8) access(k, 0, 1, a, 16'($urandom));
      else            access(k, 1, 1, a, 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
